// File: rtl/btn_msg_tx_if.sv
// Byte handshake between btn_msg_tx and the UART transmitter.
// The master offers tx_data with tx_valid; the slave accepts it with tx_ready.
interface btn_msg_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/btn_msg_tx.sv
// btn_msg_tx: turns debounced button presses into "BTN XXXX" report lines
// for the UART transmitter, where XXXX is a 4-digit uppercase hex message
// sequence number. Presses arriving while a line is being sent are queued
// in a small pending counter; presses beyond its capacity are dropped,
// flagged on o_overflow and counted on o_drop_cnt.
// Optional macro BTN_MSG_CRLF_EN: when defined, each line ends in "\r\n"
// (10 bytes); otherwise it ends in "\n" only (9 bytes).
module btn_msg_tx #(
  parameter int PEND_DEPTH = 4,
  parameter int SEQ_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_btn,
  btn_msg_tx_if.master       tx,
  output logic               o_busy,
  output logic               o_overflow,
  output logic [7:0]         o_drop_cnt
);

  localparam int PEND_W = $clog2(PEND_DEPTH + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_DEPTH);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [SEQ_W-1:0]  SEQ_ONE  = SEQ_W'(1);

`ifdef BTN_MSG_CRLF_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd8;
`endif

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            r_state;
  logic [PEND_W-1:0] r_pend;
  logic [SEQ_W-1:0]  r_seq;
  logic [15:0]       r_snap;
  logic [3:0]        r_idx;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  state_t            w_state_next;
  logic              w_dequeue;
  logic [SEQ_W-1:0]  w_seq_next;
  logic [15:0]       w_snap_next;
  logic [3:0]        w_idx_next;
  logic              w_tx_valid_next;
  logic [7:0]        w_tx_data_next;
  logic [PEND_W-1:0] w_pend_next;
  logic              w_drop;

  // One uppercase ASCII hex digit.
  function automatic logic [7:0] hexChar(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  // Byte of the report line at position idx for sequence snapshot snap.
  function automatic logic [7:0] msgByte(input logic [3:0] idx, input logic [15:0] snap);
    case (idx)
      4'd0:    return 8'h42;
      4'd1:    return 8'h54;
      4'd2:    return 8'h4E;
      4'd3:    return 8'h20;
      4'd4:    return hexChar(snap[15:12]);
      4'd5:    return hexChar(snap[11:8]);
      4'd6:    return hexChar(snap[7:4]);
      4'd7:    return hexChar(snap[3:0]);
`ifdef BTN_MSG_CRLF_EN
      4'd8:    return 8'h0D;
      4'd9:    return 8'h0A;
`else
      4'd8:    return 8'h0A;
`endif
      default: return 8'h00;
    endcase
  endfunction

  // Message FSM: IDLE starts a line whenever a press is pending, SEND walks the bytes on each accepted transfer.
  always_comb begin
    w_state_next    = r_state;
    w_dequeue       = 1'b0;
    w_seq_next      = r_seq;
    w_snap_next     = r_snap;
    w_idx_next      = r_idx;
    w_tx_valid_next = r_tx_valid;
    w_tx_data_next  = r_tx_data;
    case (r_state)
      IDLE: begin
        w_tx_valid_next = 1'b0;
        w_tx_data_next  = 8'h00;
        if (r_pend != '0) begin
          w_dequeue       = 1'b1;
          w_snap_next     = 16'(r_seq);
          w_seq_next      = r_seq + SEQ_ONE;
          w_idx_next      = 4'd0;
          w_tx_valid_next = 1'b1;
          w_tx_data_next  = msgByte(4'd0, 16'h0000);
          w_state_next    = SEND;
        end
      end
      SEND: begin
        if (r_tx_valid && tx.tx_ready) begin
          if (r_idx == LAST) begin
            w_tx_valid_next = 1'b0;
            w_tx_data_next  = 8'h00;
            w_state_next    = IDLE;
          end else begin
            w_idx_next     = r_idx + 4'd1;
            w_tx_data_next = msgByte(r_idx + 4'd1, r_snap);
          end
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_tx_valid_next = 1'b0;
        w_tx_data_next  = 8'h00;
      end
    endcase
  end

  // Press queue: a press and a dequeue in the same cycle cancel out, so a full queue never drops in that case.
  always_comb begin
    w_pend_next = r_pend;
    w_drop      = 1'b0;
    if (i_btn && !w_dequeue) begin
      if (r_pend < PEND_MAX) begin
        w_pend_next = r_pend + PEND_ONE;
      end else begin
        w_drop = 1'b1;
      end
    end else if (!i_btn && w_dequeue) begin
      w_pend_next = r_pend - PEND_ONE;
    end
  end

  // State and byte-output registers; reset abandons any partially sent line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_seq      <= '0;
      r_snap     <= 16'h0000;
      r_idx      <= 4'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_seq      <= w_seq_next;
      r_snap     <= w_snap_next;
      r_idx      <= w_idx_next;
      r_tx_valid <= w_tx_valid_next;
      r_tx_data  <= w_tx_data_next;
    end
  end

  // Pending count plus sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      r_pend <= w_pend_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign tx.tx_valid = r_tx_valid;
  assign tx.tx_data  = r_tx_data;
  assign o_busy      = (r_state != IDLE) || (r_pend != '0);
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_btn_msg_tx.sv
// Testbench for btn_msg_tx. A reference model builds each expected report
// line from the sequence number alone; monitors compare every transferred
// byte against it. A second instance with SEQ_W=4 covers sequence wrap.
module tb_btn_msg_tx;

`ifdef BTN_MSG_CRLF_EN
  localparam int MSG_LEN = 10;
`else
  localparam int MSG_LEN = 9;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  logic       busy1, ovf1, busy2, ovf2;
  logic [7:0] drop1, drop2;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0] expQ1[$];
  logic [7:0] expQ2[$];
  int expSeq1 = 0;
  int expSeq2 = 0;
  int xfer1 = 0;
  int readyMode = 0;
  int stepCnt = 0;

  btn_msg_tx_if bus1();
  btn_msg_tx_if bus2();

  btn_msg_tx dut (
    .clk        (clk),
    .reset      (reset),
    .i_btn      (btn1),
    .tx         (bus1),
    .o_busy     (busy1),
    .o_overflow (ovf1),
    .o_drop_cnt (drop1)
  );

  btn_msg_tx #(.PEND_DEPTH(4), .SEQ_W(4)) dutWrap (
    .clk        (clk),
    .reset      (reset),
    .i_btn      (btn2),
    .tx         (bus2),
    .o_busy     (busy2),
    .o_overflow (ovf2),
    .o_drop_cnt (drop2)
  );

  always #5 clk = ~clk;

  // Reference model: append the full expected line for sequence number seq.
  task automatic pushMsg(input int which, input int seq);
    logic [7:0] line[$];
    int d;
    line = '{8'h42, 8'h54, 8'h4E, 8'h20};
    for (int k = 3; k >= 0; k--) begin
      d = (seq >> (4 * k)) & 15;
      line.push_back((d < 10) ? 8'(48 + d) : 8'(65 + d - 10));
    end
`ifdef BTN_MSG_CRLF_EN
    line.push_back(8'h0D);
`endif
    line.push_back(8'h0A);
    foreach (line[i]) begin
      if (which == 1) expQ1.push_back(line[i]);
      else            expQ2.push_back(line[i]);
    end
  endtask

  // Monitor for the main instance: byte order/content and stability under backpressure.
  logic       prevValid1 = 1'b0;
  logic       prevReady1 = 1'b0;
  logic [7:0] prevData1 = 8'h00;
  always @(negedge clk) begin
    if (!reset) begin
      prevValid1 = 1'b0;
      prevReady1 = 1'b0;
    end else begin
      if (prevValid1 && !prevReady1) begin
        nCompared++;
        if (bus1.tx_valid !== 1'b1 || bus1.tx_data !== prevData1) begin
          nMismatched++;
          $display("[TB] FAIL hold_stable: got valid=%b data=%h, need valid=1 data=%h",
                   bus1.tx_valid, bus1.tx_data, prevData1);
        end
      end
      if (bus1.tx_valid === 1'b1 && bus1.tx_ready === 1'b1) begin
        nCompared++;
        if (expQ1.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL extra_byte: got %h, need no transfer", bus1.tx_data);
        end else begin
          logic [7:0] e;
          e = expQ1.pop_front();
          if (bus1.tx_data !== e) begin
            nMismatched++;
            $display("[TB] FAIL byte: got %h, need %h", bus1.tx_data, e);
          end
        end
        xfer1++;
      end
      prevValid1 = bus1.tx_valid;
      prevReady1 = bus1.tx_ready;
      prevData1  = bus1.tx_data;
    end
  end

  // Monitor for the wrap instance: byte order/content only.
  always @(negedge clk) begin
    if (reset && bus2.tx_valid === 1'b1 && bus2.tx_ready === 1'b1) begin
      nCompared++;
      if (expQ2.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL wrap_extra_byte: got %h, need no transfer", bus2.tx_data);
      end else begin
        logic [7:0] e;
        e = expQ2.pop_front();
        if (bus2.tx_data !== e) begin
          nMismatched++;
          $display("[TB] FAIL wrap_byte: got %h, need %h", bus2.tx_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    stepCnt++;
    case (readyMode)
      1: bus1.tx_ready = 1'($urandom_range(0, 1));
      2: bus1.tx_ready = ((stepCnt % 4) == 0);
      default: ;
    endcase
  endtask

  task automatic press1();
    btn1 = 1'b1;
    step();
    btn1 = 1'b0;
    pushMsg(1, expSeq1);
    expSeq1 = (expSeq1 + 1) % 65536;
  endtask

  task automatic waitIdle1(input int maxCyc);
    int c;
    c = 0;
    while (busy1 && c < maxCyc) begin
      step();
      c++;
    end
    nCompared++;
    if (busy1 !== 1'b0 || expQ1.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: got busy=%b remaining=%0d, need busy=0 remaining=0",
               busy1, expQ1.size());
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic need);
    nCompared++;
    if (got !== need) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b, need %b", name, got, need);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    bus1.tx_ready = 1'b0;
    bus2.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkBit("reset_valid", bus1.tx_valid, 1'b0);
    checkBit("reset_busy", busy1, 1'b0);
    checkBit("reset_overflow", ovf1, 1'b0);
    nCompared++;
    if (bus1.tx_data !== 8'h00 || drop1 !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL reset_data_drop: got data=%h drop=%h, need 00 00", bus1.tx_data, drop1);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    readyMode = 0;
    bus1.tx_ready = 1'b1;
    press1();
    checkBit("single_latency_valid", bus1.tx_valid, 1'b0);
    checkBit("single_latency_busy", busy1, 1'b1);
    for (int k = 0; k < MSG_LEN; k++) begin
      step();
      checkBit("single_valid_run", bus1.tx_valid, 1'b1);
    end
    step();
    checkBit("single_end_valid", bus1.tx_valid, 1'b0);
    checkBit("single_end_busy", busy1, 1'b0);
    repeat (3) step();
    press1();
    waitIdle1(60);
  endtask

  task automatic test_back_to_back();
    readyMode = 0;
    bus1.tx_ready = 1'b1;
    btn1 = 1'b1;
    step();
    pushMsg(1, expSeq1);
    expSeq1++;
    checkBit("b2b_first_wait", bus1.tx_valid, 1'b0);
    step();
    btn1 = 1'b0;
    pushMsg(1, expSeq1);
    expSeq1++;
    checkBit("b2b_first_start", bus1.tx_valid, 1'b1);
    for (int k = 1; k < MSG_LEN; k++) begin
      step();
      checkBit("b2b_run", bus1.tx_valid, 1'b1);
    end
    step();
    checkBit("b2b_gap", bus1.tx_valid, 1'b0);
    step();
    checkBit("b2b_second_start", bus1.tx_valid, 1'b1);
    waitIdle1(60);
  endtask

  task automatic test_backpressure();
    stepCnt = 0;
    readyMode = 2;
    press1();
    step();
    press1();
    waitIdle1(300);
    readyMode = 1;
    for (int b = 0; b < 3; b++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        press1();
        repeat ($urandom_range(0, 3)) step();
      end
      waitIdle1(600);
    end
    checkBit("random_no_overflow", ovf1, 1'b0);
    readyMode = 0;
    bus1.tx_ready = 1'b1;
  endtask

  task automatic test_simultaneous();
    int c;
    readyMode = 0;
    bus1.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press1();
      step();
    end
    bus1.tx_ready = 1'b1;
    c = 0;
    while (!(bus1.tx_valid === 1'b1 && bus1.tx_data === 8'h0A) && c < 50) begin
      step();
      c++;
    end
    checkBit("simul_found_last", (c < 50), 1'b1);
    step();
    btn1 = 1'b1;
    step();
    btn1 = 1'b0;
    pushMsg(1, expSeq1);
    expSeq1++;
    nCompared++;
    if (int'(dut.r_pend) != 4) begin
      nMismatched++;
      $display("[TB] FAIL simul_pend: got %0d, need 4", dut.r_pend);
    end
    checkBit("simul_no_overflow", ovf1, 1'b0);
    waitIdle1(300);
  endtask

  task automatic test_overflow();
    readyMode = 0;
    bus1.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn1 = 1'b1;
      step();
      btn1 = 1'b0;
      repeat (3) step();
    end
    for (int i = 0; i < 5; i++) begin
      pushMsg(1, expSeq1);
      expSeq1++;
    end
    checkBit("ovf_flag", ovf1, 1'b1);
    nCompared++;
    if (drop1 !== 8'd1) begin
      nMismatched++;
      $display("[TB] FAIL ovf_drop_cnt: got %0d, need 1", drop1);
    end
    bus1.tx_ready = 1'b1;
    waitIdle1(300);
    checkBit("ovf_sticky", ovf1, 1'b1);
  endtask

  task automatic test_wrap();
    int c;
    for (int i = 0; i < 17; i++) begin
      btn2 = 1'b1;
      step();
      btn2 = 1'b0;
      pushMsg(2, expSeq2);
      expSeq2 = (expSeq2 + 1) % 16;
      c = 0;
      while (busy2 && c < 60) begin
        step();
        c++;
      end
    end
    nCompared++;
    if (busy2 !== 1'b0 || expQ2.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL wrap_drain: got busy=%b remaining=%0d, need busy=0 remaining=0",
               busy2, expQ2.size());
    end
  endtask

  task automatic test_reset_mid();
    int start;
    int c;
    readyMode = 0;
    bus1.tx_ready = 1'b1;
    start = xfer1;
    press1();
    c = 0;
    while (xfer1 < start + 5 && c < 40) begin
      step();
      c++;
    end
    reset = 1'b0;
    #1;
    checkBit("midreset_valid", bus1.tx_valid, 1'b0);
    checkBit("midreset_busy", busy1, 1'b0);
    checkBit("midreset_overflow", ovf1, 1'b0);
    nCompared++;
    if (bus1.tx_data !== 8'h00 || drop1 !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL midreset_data_drop: got data=%h drop=%h, need 00 00", bus1.tx_data, drop1);
    end
    expQ1.delete();
    expSeq1 = 0;
    expQ2.delete();
    expSeq2 = 0;
    repeat (2) step();
    reset = 1'b1;
    step();
    press1();
    waitIdle1(60);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/btn_msg_tx.md
Name: btn_msg_tx

Overview:
- Sits directly downstream of the button debouncer. Consumes its single-cycle press pulse and turns each press into an ASCII report line for the UART transmitter.
- Report format: "BTN " + 4 uppercase hex digits of a message sequence number + line terminator.
- Presses are queued in a pending counter, so bursts are not lost while the UART is busy. Queue overflow is flagged and counted.
- Byte interface to the UART TX is a valid/ready handshake.

Parameters:
- PEND_DEPTH, 4: maximum queued (not yet started) presses, range 1..15.
- SEQ_W, 16: sequence counter width, range 1..16. The value is zero-extended to 16 bits for hex formatting.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i_btn  input  1  one-cycle press pulse from the debouncer. Level-high for multiple cycles counts as one press per cycle.
- tx_ready  input  1  UART TX can accept a byte this cycle.
- tx_valid  output  1  tx_data holds a valid byte.
- tx_data  output  8  ASCII byte.
- o_busy  output  1  high while a message is in flight or pend != 0.
- o_overflow  output  1  sticky; set when a press is dropped.
- o_drop_cnt  output  8  number of dropped presses, saturates at 255.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, pend=0, seq=0, idx=0.
  - tx_valid=0, tx_data=8'h00, o_busy=0, o_overflow=0, o_drop_cnt=0.
  - Applies immediately mid-message: tx_valid drops without completing the byte, and the partial message is abandoned.
- Pending counter pend, width clog2(PEND_DEPTH+1):
  - i_btn=1 and no dequeue: pend+1 if pend<PEND_DEPTH. Otherwise the press is dropped: o_overflow<=1, o_drop_cnt+1 (saturating).
  - Dequeue and no i_btn: pend-1.
  - i_btn and dequeue in the same cycle: pend unchanged, no drop, even when pend==PEND_DEPTH.
- FSM states:
  - IDLE:
    - If pend!=0: dequeue; latch snap<=seq; seq<=seq+1 (wraps modulo 2^SEQ_W); idx<=0; tx_valid<=1; tx_data<='B'; go to SEND.
    - Otherwise stay in IDLE with tx_valid=0.
  - SEND:
    - A byte transfers on a clock edge where tx_valid&tx_ready=1.
    - On transfer with idx<LAST: idx+1, tx_data<=byte[idx+1], tx_valid stays 1.
    - On transfer with idx==LAST: tx_valid<=0, tx_data<=8'h00, go to IDLE.
    - While tx_ready=0: tx_valid and tx_data are held stable.
- Message bytes, by index:
  - 0: 'B' 8'h42
  - 1: 'T' 8'h54
  - 2: 'N' 8'h4E
  - 3: ' ' 8'h20
  - 4..7: hex digits of snap[15:12], [11:8], [7:4], [3:0]; '0'-'9' = 8'h30-39, 'A'-'F' = 8'h41-46.
  - then the terminator per the optional feature.
- Back-to-back messages: IDLE always lasts exactly one cycle between messages, so there is one cycle with tx_valid=0 between the last byte and the next 'B'.
- Latency: i_btn sampled at edge N with pend=0 and IDLE gives pend=1 after edge N, and tx_valid=1 with 'B' after edge N+1.
- o_busy = (state!=IDLE) | (pend!=0), registered-equivalent (derived from registers only).
- All outputs are driven from registers. There is no combinational path from tx_ready or i_btn to any output.

Optional Feature:
- Macro BTN_MSG_CRLF_EN.
- Defined: terminator is '\r' 8'h0D then '\n' 8'h0A; LAST=9; message length 10 bytes.
- Undefined: terminator is '\n' only; LAST=8; message length 9 bytes.

Test Plan (CRLF defined, defaults unless noted):
- Single press, tx_ready held 1: one i_btn pulse -> tx_valid high 10 consecutive cycles carrying 42 54 4E 20 30 30 30 30 0D 0A. A second press later produces "BTN 0001\r\n". o_busy falls the cycle after the last byte transfers.
- Backpressure: tx_ready toggles 1,0,0,0,1,... during a message -> each byte is held stable while ready=0, and no byte is duplicated or skipped.
- Overflow: tx_ready=0, then 6 pulses spaced 4 cycles apart, then tx_ready=1 -> the first pulse is in flight and 4 are queued, the 6th is dropped. o_overflow=1, o_drop_cnt=1. Five messages are sent with sequence 0000..0004.
- Simultaneous event: with pend=PEND_DEPTH, pulse i_btn in the same cycle IDLE dequeues -> pend stays 4, o_overflow remains 0.
- Wrap: SEQ_W=4, 17 presses -> messages 0000..000F, then 0000.
- Reset mid-message: assert reset after byte 4 -> tx_valid=0 immediately, all counters cleared. The next press sends "BTN 0000\r\n". With macro undefined the same press sends 9 bytes ending in 0A.
